// File: rtl/disp_scan_ctrl_if.sv
// Value/handshake and pin bundle between the value producer and disp_scan_ctrl.
// master = value producer / board side, slave = the scan controller.
interface disp_scan_ctrl_if #(
   parameter int NUM_DIGITS = 4
);
   logic                    en;
   logic                    load;
   logic [4*NUM_DIGITS-1:0] value;
   logic                    ready;
   logic [6:0]              seg;
   logic [NUM_DIGITS-1:0]   an;
   logic                    frame_done;

   modport master (output en, load, value, input ready, seg, an, frame_done);
   modport slave  (input en, load, value, output ready, seg, an, frame_done);
endinterface

// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with dead-time guard and frame-aligned value updates.
// Optional leading-zero blanking is enabled by defining DISP_LZ_BLANK_EN.
module disp_scan_ctrl #(
   parameter int NUM_DIGITS   = 4,
   parameter int ON_CYCLES    = 1000,
   parameter int GUARD_CYCLES = 16,
   parameter bit ACTIVE_LOW   = 1'b1
) (
   input logic               clk,
   input logic               rst_n,
   disp_scan_ctrl_if.slave   bus
);
   localparam int CNT_MAX = (ON_CYCLES > GUARD_CYCLES) ? ON_CYCLES : GUARD_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX);
   localparam int IDX_W   = $clog2(NUM_DIGITS);

   localparam logic [CNT_W-1:0]      ON_LAST    = CNT_W'(ON_CYCLES - 1);
   localparam logic [CNT_W-1:0]      GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
   localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
   localparam logic [6:0]            SEG_BLANK  = ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic [NUM_DIGITS-1:0] AN_OFF     = {NUM_DIGITS{ACTIVE_LOW}};

   typedef enum logic [1:0] {S_OFF, S_ON, S_GUARD} state_e;

   state_e                  state_q;
   logic [IDX_W-1:0]        idx_q;
   logic [CNT_W-1:0]        cnt_q;
   logic [4*NUM_DIGITS-1:0] shadow_q, pend_val_q;
   logic                    pending_q, valid_q;
   logic [6:0]              seg_q, seg_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;
   logic                    frame_done_q, frame_done_d;

   logic                    accept;
   logic [3:0]              digit;
   logic [NUM_DIGITS-1:0]   sel;
   logic                    digit_blank;

   function automatic logic [6:0] hex_glyph(input logic [3:0] h);
      case (h)
         4'h0: hex_glyph = 7'h7E;
         4'h1: hex_glyph = 7'h30;
         4'h2: hex_glyph = 7'h6D;
         4'h3: hex_glyph = 7'h79;
         4'h4: hex_glyph = 7'h33;
         4'h5: hex_glyph = 7'h5B;
         4'h6: hex_glyph = 7'h5F;
         4'h7: hex_glyph = 7'h70;
         4'h8: hex_glyph = 7'h7F;
         4'h9: hex_glyph = 7'h7B;
         4'hA: hex_glyph = 7'h77;
         4'hB: hex_glyph = 7'h1F;
         4'hC: hex_glyph = 7'h4E;
         4'hD: hex_glyph = 7'h3D;
         4'hE: hex_glyph = 7'h4F;
         default: hex_glyph = 7'h47;
      endcase
   endfunction

   assign accept = bus.load & ~pending_q;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      digit = 4'h0;
      sel   = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            digit  = shadow_q[4*i +: 4];
            sel[i] = 1'b1;
         end
      end
   end

`ifdef DISP_LZ_BLANK_EN
   logic [NUM_DIGITS-1:0] lz_blank;

   // Digit i is a leading zero when it and everything above it is zero; digit 0 never is.
   always_comb begin
      lz_blank = '0;
      for (int i = 1; i < NUM_DIGITS; i++) begin
         lz_blank[i] = ((shadow_q >> (4*i)) == '0);
      end
   end

   assign digit_blank = |(sel & lz_blank);
`else
   assign digit_blank = 1'b0;
`endif

   always_comb begin
      seg_d        = SEG_BLANK;
      an_d         = AN_OFF;
      frame_done_d = bus.en && (state_q == S_GUARD) && (cnt_q == GUARD_LAST) && (idx_q == IDX_LAST);
      if (state_q == S_ON && !digit_blank) begin
         seg_d = ACTIVE_LOW ? ~hex_glyph(digit) : hex_glyph(digit);
         an_d  = AN_OFF ^ sel;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_OFF;
         idx_q        <= '0;
         cnt_q        <= '0;
         // NOTE: the value registers are reset too: blank display and no stale digits after reset.
         shadow_q     <= '0;
         pend_val_q   <= '0;
         pending_q    <= 1'b0;
         valid_q      <= 1'b0;
         seg_q        <= SEG_BLANK;
         an_q         <= AN_OFF;
         frame_done_q <= 1'b0;
      end else begin
         seg_q        <= seg_d;
         an_q         <= an_d;
         frame_done_q <= frame_done_d;

         // Straight to shadow while idle; otherwise hold until the next frame boundary.
         if (accept) begin
            valid_q <= 1'b1;
            if (state_q == S_OFF) begin
               shadow_q <= bus.value;
            end else begin
               pend_val_q <= bus.value;
               pending_q  <= 1'b1;
            end
         end

         if (!bus.en) begin
            state_q <= S_OFF;
            idx_q   <= '0;
            cnt_q   <= '0;
         end else begin
            case (state_q)
               S_OFF: begin
                  if (valid_q || accept) begin
                     state_q <= S_ON;
                     idx_q   <= '0;
                     cnt_q   <= '0;
                  end
               end
               S_ON: begin
                  if (cnt_q == ON_LAST) begin
                     state_q <= S_GUARD;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
               S_GUARD: begin
                  if (cnt_q == GUARD_LAST) begin
                     state_q <= S_ON;
                     cnt_q   <= '0;
                     if (idx_q == IDX_LAST) begin
                        idx_q <= '0;
                        if (pending_q) begin
                           shadow_q  <= pend_val_q;
                           pending_q <= 1'b0;
                        end
                     end else begin
                        idx_q <= idx_q + IDX_W'(1);
                     end
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
               default: state_q <= S_OFF;
            endcase
         end
      end
   end

   assign bus.ready      = ~pending_q;
   assign bus.seg        = seg_q;
   assign bus.an         = an_q;
   assign bus.frame_done = frame_done_q;
endmodule
